// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and helpers for the clock-gate sequencer: domain FSM encoding
// and the output decode used by every domain.
package clk_gate_ctrl_pkg;

  typedef enum logic [2:0] {
    OFF   = 3'd0,
    PEND  = 3'd1,
    WAKE  = 3'd2,
    ON    = 3'd3,
    DRAIN = 3'd4
  } dom_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Gate enable is held from the start of wake-up until the domain is fully off.
  function automatic logic en_decode(input dom_state_e s);
    return s inside {WAKE, ON, DRAIN};
  endfunction

  function automatic logic ack_decode(input dom_state_e s);
    return s inside {ON, DRAIN};
  endfunction

endpackage

// File: rtl/clk_gate_ctrl_rr_arb.sv
// Round-robin arbiter: one-hot grant among requesters, priority starting at
// the index after the last winner; no grant while en is low.
module clk_gate_ctrl_rr_arb #(
  parameter int NUM = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NUM-1:0] req,
  input  logic           en,
  output logic [NUM-1:0] gnt
);

  localparam int PTR_W = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [NUM-1:0] VEC_ONE = NUM'(1);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [NUM-1:0]   upper;
  logic [NUM-1:0]   pick_src;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    upper = '0;
    for (int j = 0; j < NUM; j++) begin
      upper[j] = req[j] && (j >= int'(ptr_q));
    end
    // Requests at or above the pointer win; otherwise wrap to the lowest index.
    pick_src = (|upper) ? upper : req;
    gnt      = en ? (pick_src & (~pick_src + VEC_ONE)) : '0;
  end

  always_comb begin
    ptr_d = ptr_q;
    for (int j = 0; j < NUM; j++) begin
      if (gnt[j]) begin
        ptr_d = (j == NUM - 1) ? '0 : PTR_W'(j + 1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-gate sequencer: per-domain wake/idle FSMs with staggered round-robin
// turn-on. Optional scan/test bypass via CLK_GATE_CTRL_TEST_BYPASS_EN.
module clk_gate_ctrl #(
  parameter int NUM_DOMAINS    = 4,
  parameter int WAKE_CYCLES    = 2,
  parameter int IDLE_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
`ifdef CLK_GATE_CTRL_TEST_BYPASS_EN
  input  logic                   test_en_i,
`endif
  input  logic [NUM_DOMAINS-1:0] req_i,
  input  logic [NUM_DOMAINS-1:0] busy_i,
  output logic [NUM_DOMAINS-1:0] en_o,
  output logic [NUM_DOMAINS-1:0] ack_o
);

  import clk_gate_ctrl_pkg::*;

  localparam int CNT_W = $clog2(max_int(WAKE_CYCLES, IDLE_CYCLES) + 1);
  localparam int STG_W = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;

  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES);
  localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [STG_W-1:0] STG_LOAD  = STG_W'(STAGGER_CYCLES - 1);
  localparam logic [STG_W-1:0] STG_ONE   = STG_W'(1);

  dom_state_e       state_q [NUM_DOMAINS];
  dom_state_e       state_d [NUM_DOMAINS];
  logic [CNT_W-1:0] cnt_q   [NUM_DOMAINS];
  logic [CNT_W-1:0] cnt_d   [NUM_DOMAINS];

  logic [STG_W-1:0]       stg_q;
  logic [STG_W-1:0]       stg_d;
  logic [NUM_DOMAINS-1:0] cand;
  logic [NUM_DOMAINS-1:0] gnt;
  logic [NUM_DOMAINS-1:0] en_d;
  logic [NUM_DOMAINS-1:0] ack_d;
  logic [NUM_DOMAINS-1:0] en_q;
  logic [NUM_DOMAINS-1:0] ack_q;
  logic                   arb_en;
  logic                   freeze;

`ifdef CLK_GATE_CTRL_TEST_BYPASS_EN
  assign freeze = test_en_i;
`else
  assign freeze = 1'b0;
`endif

  // A domain withdrawing its request this cycle is not offered to the arbiter.
  always_comb begin
    cand = '0;
    for (int d = 0; d < NUM_DOMAINS; d++) begin
      cand[d] = (state_q[d] == PEND) && req_i[d];
    end
  end

  assign arb_en = (stg_q == '0) && !freeze;

  clk_gate_ctrl_rr_arb #(
    .NUM (NUM_DOMAINS)
  ) u_arb (
    .clk (clk_i),
    .rst (rst_i),
    .req (cand),
    .en  (arb_en),
    .gnt (gnt)
  );

  always_comb begin
    stg_d = stg_q;
    if (|gnt) begin
      stg_d = STG_LOAD;
    end else if (stg_q != '0) begin
      stg_d = stg_q - STG_ONE;
    end
  end

  // Counters expire on the edge where they would reach zero, so a load of N
  // gives exactly N cycles in WAKE or DRAIN.
  always_comb begin
    en_d  = '0;
    ack_d = '0;
    for (int d = 0; d < NUM_DOMAINS; d++) begin
      state_d[d] = state_q[d];
      cnt_d[d]   = cnt_q[d];
      case (state_q[d])
        OFF: begin
          if (req_i[d]) state_d[d] = PEND;
        end
        PEND: begin
          if (!req_i[d]) begin
            state_d[d] = OFF;
          end else if (gnt[d]) begin
            state_d[d] = WAKE;
            cnt_d[d]   = WAKE_LOAD;
          end
        end
        WAKE: begin
          if (cnt_q[d] <= CNT_ONE) begin
            state_d[d] = ON;
            cnt_d[d]   = '0;
          end else begin
            cnt_d[d] = cnt_q[d] - CNT_ONE;
          end
        end
        ON: begin
          if (!req_i[d] && !busy_i[d]) begin
            state_d[d] = DRAIN;
            cnt_d[d]   = IDLE_LOAD;
          end
        end
        DRAIN: begin
          if (req_i[d] || busy_i[d]) begin
            state_d[d] = ON;
            cnt_d[d]   = '0;
          end else if (cnt_q[d] <= CNT_ONE) begin
            state_d[d] = OFF;
            cnt_d[d]   = '0;
          end else begin
            cnt_d[d] = cnt_q[d] - CNT_ONE;
          end
        end
        default: begin
          state_d[d] = OFF;
          cnt_d[d]   = '0;
        end
      endcase
      en_d[d]  = en_decode(state_d[d]);
      ack_d[d] = ack_decode(state_d[d]);
    end
  end

  // NOTE: the per-domain state and counter arrays are reset too, so outputs are defined right after reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int d = 0; d < NUM_DOMAINS; d++) begin
        state_q[d] <= OFF;
        cnt_q[d]   <= '0;
      end
      stg_q <= '0;
      en_q  <= '0;
      ack_q <= '0;
    end else begin
      if (!freeze) begin
        for (int d = 0; d < NUM_DOMAINS; d++) begin
          state_q[d] <= state_d[d];
          cnt_q[d]   <= cnt_d[d];
        end
        stg_q <= stg_d;
      end
      en_q  <= freeze ? '1 : en_d;
      ack_q <= freeze ? '1 : ack_d;
    end
  end

  assign en_o  = en_q;
  assign ack_o = ack_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed plus random bench for clk_gate_ctrl against a time-stamp based
// reference model of the wake, idle and stagger rules.
module tb_clk_gate_ctrl;

  localparam int N       = 4;
  localparam int WAKE    = 2;
  localparam int IDLE    = 16;
  localparam int STAGGER = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] busy;
  logic [N-1:0] en;
  logic [N-1:0] ack;
`ifdef CLK_GATE_CTRL_TEST_BYPASS_EN
  logic         test_en = 1'b0;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clk_gate_ctrl #(
    .NUM_DOMAINS    (N),
    .WAKE_CYCLES    (WAKE),
    .IDLE_CYCLES    (IDLE),
    .STAGGER_CYCLES (STAGGER)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
`ifdef CLK_GATE_CTRL_TEST_BYPASS_EN
    .test_en_i (test_en),
`endif
    .req_i     (req),
    .busy_i    (busy),
    .en_o      (en),
    .ack_o     (ack)
  );

  // Model: kind 0 = gated, 1 = waiting for a grant, 2 = clock enabled.
  // An enabled domain is described by its grant edge and the edge its idle period began.
  int           kind    [N];
  int           grant_e [N];
  int           idle_s  [N];
  int           last_idx;
  int           last_grant_e;
  int           edge_n = 0;
  logic [N-1:0] exp_en;
  logic [N-1:0] exp_ack;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b (edge %0d)", tag, obs, exp_v, edge_n);
    end
  endtask

  task automatic model_step();
    int g;
    g = -1;
    if (rst) begin
      for (int d = 0; d < N; d++) kind[d] = 0;
      last_idx     = N - 1;
      last_grant_e = -1000;
    end else begin
      if (edge_n - last_grant_e >= STAGGER) begin
        for (int k = 1; k <= N; k++) begin
          int j;
          j = (last_idx + k) % N;
          if (g < 0 && kind[j] == 1 && req[j]) g = j;
        end
      end
      if (g >= 0) begin
        last_idx     = g;
        last_grant_e = edge_n;
      end
      for (int d = 0; d < N; d++) begin
        case (kind[d])
          0: if (req[d]) kind[d] = 1;
          1: begin
            if (!req[d]) kind[d] = 0;
            else if (g == d) begin
              kind[d]    = 2;
              grant_e[d] = edge_n;
              idle_s[d]  = -1;
            end
          end
          default: begin
            if (edge_n > grant_e[d] + WAKE) begin
              if (idle_s[d] < 0) begin
                if (!req[d] && !busy[d]) idle_s[d] = edge_n;
              end else if (req[d] || busy[d]) begin
                idle_s[d] = -1;
              end else if (edge_n >= idle_s[d] + IDLE) begin
                kind[d] = 0;
              end
            end
          end
        endcase
      end
    end
    for (int d = 0; d < N; d++) begin
      exp_en[d]  = (kind[d] == 2);
      exp_ack[d] = (kind[d] == 2) && (edge_n >= grant_e[d] + WAKE);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    model_step();
    #1;
    check("model_en", en, exp_en);
    check("model_ack", ack, exp_ack);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    busy = '0;
    ticks(2);
    check("reset_en", en, 4'b0000);
    check("reset_ack", ack, 4'b0000);
    rst = 1'b0;
    tick();

    // Single request: enable one edge after pending, ack WAKE edges later.
    req = 4'b0001;
    tick();
    check("s1_pend_en", en, 4'b0000);
    tick();
    check("s1_grant_en", en, 4'b0001);
    check("s1_grant_ack", ack, 4'b0000);
    tick();
    check("s1_wake_ack", ack, 4'b0000);
    tick();
    check("s1_ack", ack, 4'b0001);

    // Idle gate-off exactly IDLE edges after drain entry.
    ticks(3);
    req = 4'b0000;
    tick();
    ticks(15);
    check("s3_hold_en", en, 4'b0001);
    check("s3_hold_ack", ack, 4'b0001);
    tick();
    check("s3_off_en", en, 4'b0000);
    check("s3_off_ack", ack, 4'b0000);

    // Busy pulse during drain restarts the full idle period.
    req = 4'b0001;
    ticks(5);
    check("s4_on", ack, 4'b0001);
    req = 4'b0000;
    tick();
    ticks(9);
    busy = 4'b0001;
    tick();
    busy = 4'b0000;
    tick();
    ticks(15);
    check("s4_hold", en, 4'b0001);
    tick();
    check("s4_off", en, 4'b0000);

    // All four request together: grants STAGGER apart in index order.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    tick();
    tick();
    check("s2_grant0", en, 4'b0001);
    ticks(2);
    check("s2_ack0", ack, 4'b0001);
    ticks(2);
    check("s2_grant1", en, 4'b0011);
    ticks(2);
    check("s2_ack1", ack, 4'b0011);
    ticks(4);
    check("s2_ack2", ack, 4'b0111);
    ticks(4);
    check("s2_ack3", ack, 4'b1111);

    // Round-robin continues after the last winner (2): domain 3 beats 1.
    rst = 1'b1;
    req = 4'b0000;
    tick();
    rst = 1'b0;
    req = 4'b0100;
    ticks(2);
    check("s5_grant2", en, 4'b0100);
    req = 4'b1110;
    ticks(3);
    check("s5_blocked", en, 4'b0100);
    tick();
    check("s5_first3", en, 4'b1100);
    ticks(3);
    check("s5_wait1", en, 4'b1100);
    tick();
    check("s5_then1", en, 4'b1110);

    // Reset mid-wake clears outputs and the round-robin pointer.
    rst = 1'b1;
    req = 4'b0000;
    tick();
    rst = 1'b0;
    req = 4'b0010;
    ticks(2);
    check("s6_wake", en, 4'b0010);
    rst = 1'b1;
    tick();
    check("s6_rst_en", en, 4'b0000);
    check("s6_rst_ack", ack, 4'b0000);
    rst = 1'b0;
    req = 4'b0011;
    ticks(2);
    check("s6_first0", en, 4'b0001);
    ticks(4);
    check("s6_then1", en, 4'b0011);

    // Random traffic: sticky requests, sporadic busy and occasional reset.
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
        busy[b] = ($urandom_range(0, 3) == 0);
      end
      rst = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst  = 1'b0;
    req  = '0;
    busy = '0;
    ticks(IDLE + WAKE + 4);
    check("final_all_off", en, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_gate_ctrl.md
# clk_gate_ctrl

Sequencer and arbiter for a bank of `clk_gate` cells inside the CRG. It drives one `en_i` per gated clock domain from domain request and activity inputs. Turn-ons are serialised round-robin and spaced a fixed number of cycles apart to limit current surge. A domain is gated off automatically after a programmable idle period. It runs on the ungated root clock, upstream of the gate cells.

## Interface
Parameters:
- `NUM_DOMAINS`, 4: number of gated domains (≥1).
- `WAKE_CYCLES`, 2: cycles between `en_o` rising and `ack_o` rising (≥1).
- `IDLE_CYCLES`, 16: idle cycles before gate-off (≥1).
- `STAGGER_CYCLES`, 4: minimum cycle spacing between two turn-on grants (≥1; 1 = back-to-back).

Ports (one clock; reset is synchronous and active-high):
- `clk_i`  in  1  root clock, ungated
- `rst_i`  in  1  synchronous reset, active-high
- `req_i`  in  NUM_DOMAINS  domain requests its clock
- `busy_i`  in  NUM_DOMAINS  domain still active; keeps clock alive
- `en_o`  out  NUM_DOMAINS  to `clk_gate.en_i` of each domain
- `ack_o`  out  NUM_DOMAINS  domain clock running and stable

## Operation
- Each domain has its own FSM with states OFF, PEND, WAKE, ON, DRAIN, plus a down-counter.
- Transitions:
  - OFF→PEND when `req_i`=1.
  - PEND→OFF when `req_i`=0 (withdrawn request).
  - PEND→WAKE on grant; counter loads WAKE_CYCLES.
  - WAKE→ON when counter reaches 0; this happens unconditionally, even if `req_i` drops.
  - ON→DRAIN when `req_i`=0 and `busy_i`=0; counter loads IDLE_CYCLES.
  - DRAIN→ON when `req_i`=1 or `busy_i`=1; the counter is discarded.
  - DRAIN→OFF when counter reaches 0.
- Outputs:
  - `en_o`=1 in WAKE, ON and DRAIN.
  - `ack_o`=1 in ON and DRAIN.
  - Both outputs are registered, decoded from the next state.
- Scheduler:
  - At most one grant per cycle.
  - The candidates are the domains in PEND.
  - Round-robin priority starts at the index after the last granted domain; the pointer resets to 0.
  - A grant is blocked while the stagger timer is nonzero.
  - Each grant loads the stagger timer with STAGGER_CYCLES−1; the timer decrements to 0.
- Counter width is `$clog2(max(WAKE_CYCLES,IDLE_CYCLES)+1)`. The stagger timer is `$clog2(STAGGER_CYCLES)` wide, minimum 1. Counters saturate at 0 and never wrap.
- Reset values: all FSMs OFF, `en_o`=0, `ack_o`=0, RR pointer 0, stagger timer 0.

## Timing
- `req_i` is sampled at edge t: PEND after t, grant at edge t+1 (if the timer is 0 and the domain wins arbitration), `en_o`=1 after t+1, `ack_o`=1 after t+1+WAKE_CYCLES.
- Minimum request-to-ack latency: 2+WAKE_CYCLES edges.
- Entry to DRAIN at edge k with no reactivation gives `en_o`=`ack_o`=0 after edge k+IDLE_CYCLES.
- Grants to different domains are at least STAGGER_CYCLES edges apart.
- Gate-offs are never staggered; simultaneous gate-offs are allowed.
- `rst_i` overrides all other inputs, including mid-WAKE or mid-DRAIN; outputs are 0 after that edge.

## Configuration
- `CLK_GATE_CTRL_TEST_BYPASS_EN` defined:
  - Adds port `test_en_i` (in, 1).
  - While it is 1, all `en_o` and `ack_o` are 1 in the next cycle.
  - The FSMs, scheduler and counters are frozen.
  - On release, the outputs return to their FSM-decoded values in the next cycle.
- Not defined: the port is absent and there is no bypass logic.

## Structure
- `clk_gate_ctrl_pkg`: contains the `dom_state_e` enum (OFF, PEND, WAKE, ON, DRAIN).
- Sub-module `clk_gate_ctrl_rr_arb`: a NUM_DOMAINS-wide round-robin arbiter with a request vector, an enable input (stagger timer = 0), a one-hot grant output and an internal pointer.

## Test plan
Defaults: N=4, WAKE=2, IDLE=16, STAGGER=4.
1. `req_i[0]` rises, sampled at edge 1 → `en_o[0]`=1 after edge 2, `ack_o[0]`=1 after edge 4; other bits stay 0.
2. `req_i`=4'b1111 sampled at edge 1 → grants to domains 0,1,2,3 at edges 2,6,10,14; `ack_o` bits rise at edges 4,8,12,16.
3. Domain 0 ON; `req_i[0]`/`busy_i[0]` fall, sampled at edge 20 → `en_o[0]`,`ack_o[0]` stay 1 through edge 35 and are 0 after edge 36.
4. DRAIN as in scenario 3, `busy_i[0]` pulses for one cycle, sampled at edge 30 → stays ON; a later idle of 16 cycles is required before gate-off.
5. Last grant went to domain 2; domains 1 and 3 both PEND with timer 0 → domain 3 is granted first, then domain 1 STAGGER cycles later.
6. `rst_i` asserted while domain 1 is in WAKE → `en_o`=`ack_o`=0 after that edge; the next `req_i`=4'b0011 grants domain 0 first.
